// File: rtl/mf8_lsu.sv
// mf8 load/store unit: handshaked data-RAM access with pointer addressing modes,
// ram_ready wait states and a bounded-timeout abort.
module mf8_lsu #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int DISP_W  = 6,
  parameter int TMO_CYC = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_mode,
  input  logic [DISP_W-1:0] req_disp,
  input  logic [ADDR_W-1:0] ptr_in,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              ptr_wr,
  output logic [ADDR_W-1:0] ptr_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_datain,
  input  logic              ram_ready
);

  localparam int CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ptr_wr_q, ptr_wr_d;
  logic              ptr_upd_q, ptr_upd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] ptr_out_q, ptr_out_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_read_q, ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] new_ptr;

  always_comb begin
    eff_addr = ptr_in;
    new_ptr  = ptr_in;
    unique case (req_mode)
      2'b01:   new_ptr = ptr_in + ADDR_W'(1);
      2'b10: begin
        eff_addr = ptr_in - ADDR_W'(1);
        new_ptr  = ptr_in - ADDR_W'(1);
      end
      2'b11:   eff_addr = ptr_in + ADDR_W'(req_disp);
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ptr_wr_d    = 1'b0;
    ptr_upd_d   = ptr_upd_q;
    rdata_d     = rdata_q;
    ptr_out_d   = ptr_out_q;
    ram_addr_d  = ram_addr_q;
    ram_read_d  = ram_read_q;
    ram_write_d = ram_write_q;
    ram_wdata_d = ram_wdata_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        if (req) begin
          state_d     = ACCESS;
          ram_addr_d  = eff_addr;
          ram_wdata_d = req_wdata;
          ram_read_d  = ~req_we;
          ram_write_d = req_we;
          ptr_out_d   = new_ptr;
          ptr_upd_d   = req_mode[0] ^ req_mode[1];
          cnt_d       = '0;
        end
      end
      ACCESS: begin
        // A ready arriving in the same cycle the counter hits the limit wins.
        if (ram_ready) begin
          state_d     = IDLE;
          ram_read_d  = 1'b0;
          ram_write_d = 1'b0;
          done_d      = 1'b1;
          ptr_wr_d    = ptr_upd_q;
          if (ram_read_q) rdata_d = ram_datain;
        end else if (TMO_CYC != 0 && cnt_q == TMO_LIM) begin
          state_d     = IDLE;
          ram_read_d  = 1'b0;
          ram_write_d = 1'b0;
          done_d      = 1'b1;
          err_d       = 1'b1;
          rdata_d     = '0;
        end else if (TMO_CYC != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ptr_wr_q    <= 1'b0;
      ptr_upd_q   <= 1'b0;
      rdata_q     <= '0;
      ptr_out_q   <= '0;
      ram_addr_q  <= '0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_wdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ptr_wr_q    <= ptr_wr_d;
      ptr_upd_q   <= ptr_upd_d;
      rdata_q     <= rdata_d;
      ptr_out_q   <= ptr_out_d;
      ram_addr_q  <= ram_addr_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_wdata_q <= ram_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = (state_q == ACCESS);
  assign done      = done_q;
  assign err       = err_q;
  assign ptr_wr    = ptr_wr_q;
  assign rdata     = rdata_q;
  assign ptr_out   = ptr_out_q;
  assign ram_addr  = ram_addr_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/mf8_lsu.md
Name: mf8_lsu

Overview:
- Parametrised load/store unit for the next-generation mf8 core.
- Replaces the fixed single-cycle LD/ST Z path with a handshaked data-memory access.
- Supports four pointer addressing modes (plain, post-increment, pre-decrement, displacement), honours ram_ready wait states, and aborts on a bounded timeout.
- Sits between instruction decode/register file and the data RAM port; stalls the core via busy.

Parameters:
ADDR_W, 16, width of pointer and RAM address
DATA_W, 8, width of RAM data
DISP_W, 6, width of unsigned displacement field
TMO_CYC, 15, max wait cycles for ram_ready before abort; 0 disables timeout

Ports:
Clk  in  1  clock, all state on rising edge
Reset_n  in  1  asynchronous active-low reset
req  in  1  access request, sampled only while state is IDLE
req_we  in  1  1 = store, 0 = load
req_mode  in  2  00 plain, 01 post-inc, 10 pre-dec, 11 displacement
req_disp  in  DISP_W  displacement, zero-extended, used in mode 11 only
ptr_in  in  ADDR_W  current pointer register value (Z)
req_wdata  in  DATA_W  store data
busy  out  1  access in flight; core must hold PC/Inst
done  out  1  one-cycle pulse, access complete (success or abort)
err  out  1  one-cycle pulse coincident with done on timeout abort
rdata  out  DATA_W  load data, valid in the done cycle, held until next done
ptr_wr  out  1  one-cycle pulse: write ptr_out back to pointer register
ptr_out  out  ADDR_W  updated pointer value
ram_addr  out  ADDR_W  RAM address
ram_read  out  1  read strobe, level, held until ram_ready
ram_write  out  1  write strobe, level, held until ram_ready
ram_wdata  out  DATA_W  RAM write data
ram_datain  in  DATA_W  RAM read data, valid when ram_ready=1
ram_ready  in  1  RAM completes current access this cycle

Behaviour:
- Reset (async): state IDLE; busy, done, err, ptr_wr, ram_read, ram_write = 0; rdata, ram_addr, ram_wdata, ptr_out, timeout counter = 0.
- States: IDLE, ACCESS.
- IDLE, req=1 at edge N: latch the effective address, store data, req_we and the new pointer value; go to ACCESS.
  - Effective address: mode 00/01 = ptr_in; mode 10 = ptr_in-1; mode 11 = ptr_in + disp.
  - All arithmetic is modulo 2^ADDR_W (0x0000-1 = 0xFFFF; 0xFFFF+1 = 0x0000).
  - New pointer: mode 01 = ptr_in+1; mode 10 = ptr_in-1; mode 00/11 = unchanged, and ptr_wr never pulses.
- ACCESS:
  - ram_read or ram_write high, busy high; ram_addr and ram_wdata stable throughout.
  - When ram_ready=1: load captures ram_datain into rdata; go to IDLE; next cycle done=1, and ptr_wr=1 if the mode is 01/10.
  - Strobes drop in the cycle after ram_ready.
- Minimum latency: req at N, strobe during N+1, ram_ready in N+1 gives done at N+2. Each wait cycle adds 1.
- Timeout (TMO_CYC>0):
  - Counter clears on entry to ACCESS and increments each cycle ram_ready=0.
  - When it reaches TMO_CYC with ram_ready still 0: go to IDLE; next cycle done=1, err=1.
  - On abort: ptr_wr=0 and rdata=0.
  - ram_ready=1 in the same cycle the counter reaches TMO_CYC counts as success.
- Back-to-back: IDLE with done=1 accepts a new req in that same cycle. No bubble beyond the done cycle.
- req while in ACCESS is ignored, with no queuing.
- Only one of ram_read/ram_write is ever high. Neither is high in IDLE.
- ram_ready while in IDLE is ignored.
- Reset mid-access drops the strobes immediately; no done or ptr_wr is issued.

Test Plan:
- Load, mode 01, ptr_in=0x00FF, ram_ready tied 1, ram_datain=0xA5 -> ram_addr=0x00FF, ram_read one cycle; done at N+2 with rdata=0xA5, ptr_wr=1, ptr_out=0x0100.
- Store, mode 10, ptr_in=0x0000, req_wdata=0x3C, ram_ready after 3 wait cycles -> ram_addr=0xFFFF, ram_write held 4 cycles, ram_wdata=0x3C; done at N+5, ptr_out=0xFFFF.
- Load, mode 11, ptr_in=0xFFF0, disp=0x3F -> ram_addr=0x002F; ptr_wr stays 0.
- ram_ready never asserted, TMO_CYC=15 -> strobe drops after 15 wait cycles; done=err=1 together, rdata=0x00, ptr_wr=0. Repeat with ram_ready arriving exactly on cycle 15 -> done=1, err=0.
- Two requests back-to-back, second req asserted in first done cycle -> second strobe begins the next cycle; req pulses during ACCESS produce no extra accesses.
- Reset_n asserted during a waited store -> ram_write=0 immediately; no done/ptr_wr after release; a fresh req then completes normally.
